if_stage: RTL
=============

# if_stage

Instruction-fetch stage feeding the IF/ID pipeline register. Holds the program counter, drives the combinational instruction-memory address, and predicts conditional branches with a 128-entry table of 2-bit saturating counters. Its outputs (PC, instruction, predicted-taken bit, 7-bit table index) map one-to-one onto the IF/ID register's four data inputs. Table training and mispredict redirects come back from the EX stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- BHT_IDX_W, 7, table index width; table depth is 2**BHT_IDX_W

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard stall; holds the PC and suppresses table training
- redirect  in  1  EX-resolved mispredict or jump correction
- redirect_pc  in  32  correct next PC when redirect=1
- upd_valid  in  1  EX resolved a conditional branch this cycle
- upd_idx  in  BHT_IDX_W  table index carried down the pipe with that branch
- upd_taken  in  1  actual branch outcome
- im_addr  out  32  instruction-memory address; equals the PC register
- im_data  in  32  instruction word; combinational read of im_addr
- pc_out  out  32  PC of the fetched instruction; goes to IF/ID d_in1
- inst_out  out  32  im_data passed through; goes to IF/ID d_in2
- pred_taken  out  1  prediction for inst_out; goes to IF/ID d_in3
- bht_idx  out  BHT_IDX_W  pc[BHT_IDX_W+1:2]; goes to IF/ID d_in4
- if_flush  out  1  equals redirect; clears the IF/ID contents downstream

## Operation
- PC register, 32 bits. Next-PC priority: rst → RESET_PC; redirect → redirect_pc; stall → hold; pred_taken → pc + imm; otherwise pc + 4.
- Redirect overrides stall.
- Decode of im_data, combinational:
  - B-type (opcode 7'b1100011): pred_taken = bht[bht_idx][1]; imm = sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - JAL (7'b1101111): pred_taken = 1; imm = sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - All other opcodes: pred_taken = 0.
- All address arithmetic is 32-bit modulo 2^32. Wrap-around is silent.
- Table: 2**BHT_IDX_W entries, 2-bit counters. Every entry resets to 2'b01 (weakly not-taken).
  - On upd_valid & ~stall: increment toward 2'b11 when upd_taken=1, decrement toward 2'b00 when upd_taken=0. The counter saturates at both ends.
- Training occurs on upd_valid & ~stall regardless of redirect.
- Read/update collision: an update and a lookup on the same index in the same cycle → the lookup returns the pre-update value. No bypass.
- rst mid-operation: the PC and all counters reinitialise on that edge. In-flight updates are discarded.

## Timing
- Fetch outputs are combinational from the PC register and im_data. There is zero added latency; IF/ID registers them.
- Redirect asserted in cycle N → im_addr = redirect_pc in cycle N+1. if_flush is high in cycle N only.
- A table update at edge N is visible to lookups from cycle N+1.
- Reset values, with rst held high: im_addr = pc_out = RESET_PC, if_flush = redirect (0 when idle), and all counters = 2'b01.
- inst_out, pred_taken and bht_idx follow im_data and the PC and have no reset value of their own.
- A stall held for K cycles keeps im_addr constant for K cycles, then advances on the first cycle with stall=0.

## Configuration
- Macro: IF_STAGE_BHT_EN.
- Defined: counter table and B-type prediction as described above.
- Undefined:
  - No table storage is built.
  - B-type pred_taken = 0 (static not-taken); JAL is still predicted taken.
  - upd_* inputs are ignored.
  - bht_idx is still driven as pc[BHT_IDX_W+1:2].

## Structure
- Shared package holds:
  - opcode constants OP_BRANCH and OP_JAL
  - counter type and the constants CNT_WNT = 2'b01 and CNT_ST = 2'b11
  - a function computing the B-type and J-type immediates
- One sub-module: bht_2bit, holding the counter array with one async-read port and one sync-write port, reset to CNT_WNT.
- if_stage holds the PC, next-PC mux and decode.

## Test plan
- Reset, then 3 cycles of NOPs (32'h0000_0013) → im_addr sequence 0x0, 0x4, 0x8, 0xC; pred_taken = 0 throughout.
- JAL imm = +16 fetched at 0x8 → pred_taken = 1 and next im_addr = 0x18.
- B-type imm = −8 at 0x40, two updates with upd_idx = 16 and upd_taken = 1 → prediction flips from 0 to 1; next im_addr = 0x38.
- Four updates to idx 5 with upd_taken = 0 → counter saturates at 2'b00. A single taken update → 2'b01, still predicting not-taken.
- stall = 1 together with redirect = 1 and redirect_pc = 0x200 → next im_addr = 0x200 and if_flush = 1 that cycle. stall alone for 3 cycles → im_addr held.
- rst asserted mid-run after training idx 16 to 2'b11 → PC returns to RESET_PC and idx 16 reads 2'b01. Without IF_STAGE_BHT_EN, the same B-type sequence never predicts taken.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared opcode, counter and immediate-decode definitions for the fetch stage.
package if_stage_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_WNT = 2'b01;
  localparam cnt_t CNT_ST  = 2'b11;

  // Sign-extended target offset for B-type and JAL; zero for anything else.
  function automatic logic [31:0] branch_imm(input logic [31:0] inst);
    case (inst[6:0])
      OP_BRANCH: return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_JAL:    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/if_stage_bht_2bit.sv
// Branch history table: 2-bit saturating counters, async read, sync write,
// every entry reset to weakly-not-taken.
module bht_2bit
  import if_stage_pkg::*;
#(
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output cnt_t             rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int DEPTH = 1 << IDX_W;

  cnt_t cnt_q [DEPTH];

  function automatic cnt_t sat_step(input cnt_t c, input logic taken);
    if (taken) return (c == CNT_ST) ? c : cnt_t'(c + 2'd1);
    else       return (c == 2'b00)  ? c : cnt_t'(c - 2'd1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_WNT;
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= sat_step(cnt_q[wr_idx_i], wr_taken_i);
    end
  end

  // Read sees the pre-update value on a same-index collision.
  assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and branch prediction.
// Define IF_STAGE_BHT_EN to build the 2-bit counter table for B-type prediction.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  input  logic                 upd_valid,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken,
  output logic [31:0]          im_addr,
  input  logic [31:0]          im_data,
  output logic [31:0]          pc_out,
  output logic [31:0]          inst_out,
  output logic                 pred_taken,
  output logic [BHT_IDX_W-1:0] bht_idx,
  output logic                 if_flush
);

  logic [31:0] pc_q, pc_d;
  logic        is_br, is_jal, br_pred;

  assign is_br   = (im_data[6:0] == OP_BRANCH);
  assign is_jal  = (im_data[6:0] == OP_JAL);
  assign bht_idx = pc_q[BHT_IDX_W+1:2];

`ifdef IF_STAGE_BHT_EN
  cnt_t rd_cnt;
  logic unused_cnt;

  bht_2bit #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (bht_idx),
    .rd_cnt_o   (rd_cnt),
    .wr_en_i    (upd_valid & ~stall),
    .wr_idx_i   (upd_idx),
    .wr_taken_i (upd_taken)
  );

  assign br_pred    = rd_cnt[1];
  assign unused_cnt = rd_cnt[0];
`else
  logic unused_upd;

  // Static not-taken for conditional branches; training inputs are ignored.
  assign br_pred    = 1'b0;
  assign unused_upd = ^{upd_valid, upd_idx, upd_taken};
`endif

  assign pred_taken = is_jal | (is_br & br_pred);

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redirect)        pc_d = redirect_pc;
    else if (stall)      pc_d = pc_q;
    else if (pred_taken) pc_d = pc_q + branch_imm(im_data);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign im_addr  = pc_q;
  assign pc_out   = pc_q;
  assign inst_out = im_data;
  assign if_flush = redirect;

endmodule
